// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, configuration codes and width mapping
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] CFG_8B = 2'b00;
  localparam logic [1:0] CFG_7B = 2'b01;
  localparam logic [1:0] CFG_6B = 2'b11;
  localparam logic [1:0] CFG_5B = 2'b10;

  // Same mapping the transmitter uses, so both ends agree on frame length.
  function automatic logic [3:0] cfg_to_bits(input logic [1:0] cfg);
    case (cfg)
      CFG_8B:  return 4'd8;
      CFG_7B:  return 4'd7;
      CFG_6B:  return 4'd6;
      default: return 4'd5;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchroniser for rx with registered previous value and falling-edge flag
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  // All flops reset to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 5-8 data bits; UART_RX_PARITY_EN adds even parity
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] configuration,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_t     state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    sreg, sreg_n;
  logic [3:0]    n_bits, n_bits_n;
  logic [7:0]    data_n;
  logic          valid_n;
  logic          ferr_n;
  logic          busy_n;
  logic [2:0]    last_bit;
  logic [7:0]    word;
  logic          bit_end;

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_n;
  logic perr_n;
`endif

  assign last_bit = 3'(n_bits - 4'd1);
  // Bits enter at the top, so an n-bit frame sits in sreg[7:8-n]; shifting down right-aligns and zero-fills.
  assign word     = sreg >> (4'd8 - n_bits);
  assign bit_end  = sample_tick && (tcnt == T_LAST);

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    bcnt_n   = bcnt;
    sreg_n   = sreg;
    n_bits_n = n_bits;
    data_n   = data;
    valid_n  = 1'b0;
    ferr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n    = par_bit;
    perr_n   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (fall) begin
          n_bits_n = cfg_to_bits(configuration);
          tcnt_n   = '0;
          state_n  = S_START;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (tcnt == T_MID) begin
            if (!rx_s) begin
              tcnt_n  = '0;
              bcnt_n  = '0;
              state_n = S_DATA;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sreg_n = {rx_s, sreg[7:1]};
          bcnt_n = bcnt + 1'b1;
          tcnt_n = '0;
          if (bcnt == last_bit) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end else if (sample_tick) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          par_n   = rx_s;
          tcnt_n  = '0;
          state_n = S_STOP;
        end else if (sample_tick) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          tcnt_n  = '0;
          state_n = S_IDLE;
          data_n  = word;
          if (rx_s) begin
            valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_n  = (par_bit != ^word);
`endif
          end else begin
            ferr_n = 1'b1;
          end
        end else if (sample_tick) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      tcnt          <= '0;
      bcnt          <= '0;
      sreg          <= '0;
      n_bits        <= 4'd8;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      tcnt          <= tcnt_n;
      bcnt          <= bcnt_n;
      sreg          <= sreg_n;
      n_bits        <= n_bits_n;
      data          <= data_n;
      valid         <= valid_n;
      framing_error <= ferr_n;
      busy          <= busy_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_bit      <= par_n;
      parity_error <= perr_n;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] configuration = 2'b00;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .rx            (rx),
    .configuration (configuration),
    .data          (data),
    .valid         (valid),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int tick_div = 1;
  int tick_phase = 0;
  always @(negedge clk) begin
    if (tick_phase >= tick_div - 1) begin
      tick_phase  = 0;
      sample_tick = 1'b1;
    end else begin
      tick_phase  = tick_phase + 1;
      sample_tick = 1'b0;
    end
  end

  int   valid_cnt = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;
  logic busy_at_valid = 1'b0;
  logic busy_before_valid = 1'b0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt         = valid_cnt + 1;
      busy_at_valid     = busy;
      busy_before_valid = busy_prev;
    end
    if (framing_error) ferr_cnt = ferr_cnt + 1;
    if (parity_error)  perr_cnt = perr_cnt + 1;
    busy_prev = busy;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbits_of(input logic [1:0] c);
    case (c)
      2'b00:   return 8;
      2'b01:   return 7;
      2'b11:   return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [7:0] expect_word(input logic [7:0] b, input int n);
    int v;
    v = b % (1 << n);
    return 8'(v);
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * OS * tick_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] cfg, input logic stop_bit,
                            input logic par_good, input logic [1:0] cfg_mid);
    int n;
    logic [7:0] w;
    n = nbits_of(cfg);
    w = expect_word(b, n);
    configuration = cfg;
    drive_bit(1'b0);
    configuration = cfg_mid;
    for (int i = 0; i < n; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(($countones(w) % 2 == 1) ? par_good : ~par_good);
`else
    if (par_good && w == 8'hxx) rx = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic run_good(input string tag, input logic [7:0] b, input logic [1:0] cfg,
                          input logic [1:0] cfg_mid, input logic par_good);
    int v0, f0, p0, exp_perr;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    send_frame(b, cfg, 1'b1, par_good, cfg_mid);
    idle(2);
`ifdef UART_RX_PARITY_EN
    exp_perr = par_good ? 0 : 1;
`else
    exp_perr = 0;
`endif
    check({tag, "_valid"}, valid_cnt - v0, 1);
    check({tag, "_ferr"},  ferr_cnt - f0, 0);
    check({tag, "_perr"},  perr_cnt - p0, exp_perr);
    check({tag, "_data"},  data, expect_word(b, nbits_of(cfg)));
    check({tag, "_busy"},  busy, 0);
  endtask

  initial begin
    int v0, f0, p0;
    logic [7:0] b;
    logic [1:0] c, cm;
    logic pg;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data",  data, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr",  framing_error, 0);
    check("rst_perr",  parity_error, 0);
    check("rst_busy",  busy, 0);
    idle(1);

    run_good("a5", 8'hA5, 2'b00, 2'b00, 1'b1);
    check("a5_busy_at_valid",     busy_at_valid, 0);
    check("a5_busy_before_valid", busy_before_valid, 1);

    run_good("w6", 8'h2D, 2'b11, 2'b11, 1'b1);
    run_good("w5", 8'h1F, 2'b10, 2'b10, 1'b1);
    run_good("w7", 8'hFF, 2'b01, 2'b00, 1'b1);

    // Break: bad stop bit then line held low; only one error, no re-reception.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    check("brk_ferr",  ferr_cnt - f0, 1);
    check("brk_valid", valid_cnt - v0, 0);
    check("brk_data",  data, 8'h5A);
    check("brk_busy",  busy, 0);
    idle(2);
    run_good("after_brk", 8'h3C, 2'b00, 2'b00, 1'b1);
    check("brk_ferr_total", ferr_cnt - f0, 1);

    // Short low glitch on idle line.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", busy, 1);
    idle(2);
    check("glitch_busy_lo", busy, 0);
    check("glitch_valid",   valid_cnt - v0, 0);
    check("glitch_ferr",    ferr_cnt - f0, 0);
    check("glitch_perr",    perr_cnt - p0, 0);

    // Reset in the middle of bit 3 of 0x55.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    configuration = 2'b00;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(i % 2 == 0);
    rx = 1'b0;
    repeat (OS / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_data",  data, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_valid", valid, 0);
    reset = 1'b0;
    idle(2);
    check("mid_rst_nopulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    run_good("after_rst", 8'h81, 2'b00, 2'b00, 1'b1);

`ifdef UART_RX_PARITY_EN
    tick_div = 3;
    idle(1);
    run_good("par_ok",  8'h07, 2'b00, 2'b00, 1'b1);
    run_good("par_bad", 8'h07, 2'b00, 2'b00, 1'b0);
`endif

    for (int k = 0; k < 10; k++) begin
      tick_div = $urandom_range(1, 3);
      idle(1);
      b  = 8'($urandom);
      c  = 2'($urandom);
      cm = 2'($urandom);
      pg = 1'($urandom);
      run_good($sformatf("rnd%0d", k), b, c, cm, pg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
